// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the core-port to APB3 bridge.
// The watchdog (macro APB_MEM_BRIDGE_TIMEOUT_EN) takes its default limit from here.
package apb_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 256;

   // Clears the byte-offset bits; the bridge only issues word transfers.
   localparam logic [63:0] WORD_ALIGN_MASK = ~64'h3;

endpackage

// File: rtl/apb_bridge_wdog.sv
// pready watchdog for apb_mem_bridge; compiled only with APB_MEM_BRIDGE_TIMEOUT_EN.
// Counts ACCESS cycles without pready and flags the cycle in which the limit is reached.
`ifdef APB_MEM_BRIDGE_TIMEOUT_EN
module apb_bridge_wdog
   import apb_bridge_pkg::*;
#(
   parameter int unsigned LIMIT = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic count_i,
   output logic expire_o
);

   // The count never has to hold LIMIT itself: the abort fires on the cycle that would reach it.
   localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (count_i) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = count_i && (cnt_q == LAST);

endmodule
`endif

// File: rtl/apb_mem_bridge.sv
// Single-outstanding core req/gnt/rvalid port to APB3 master bridge.
// Macro APB_MEM_BRIDGE_TIMEOUT_EN adds a pready watchdog (apb_bridge_wdog) and sticky timeout_o.
module apb_mem_bridge
   import apb_bridge_pkg::*;
#(
   parameter int unsigned APB_ADDR_WIDTH = 32,
   parameter int unsigned APB_DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      req_i,
   input  logic                      we_i,
   input  logic [APB_ADDR_WIDTH-1:0] addr_i,
   input  logic [APB_DATA_WIDTH-1:0] wdata_i,
   output logic                      gnt_o,
   output logic                      rvalid_o,
   output logic [APB_DATA_WIDTH-1:0] rdata_o,
   output logic                      err_o,
   output logic                      psel_o,
   output logic                      penable_o,
   output logic                      pwrite_o,
   output logic [APB_ADDR_WIDTH-1:0] paddr_o,
   output logic [APB_DATA_WIDTH-1:0] pwdata_o,
   input  logic [APB_DATA_WIDTH-1:0] prdata_i,
   input  logic                      pready_i,
   input  logic                      pslverr_i,
   output logic                      timeout_o
);

   apb_state_e                state_q, state_d;
   logic                      we_q, we_d;
   logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                      rvalid_q, rvalid_d;
   logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                      err_q, err_d;
   logic                      gnt;
   logic                      in_xfer;
   logic                      wd_expire;

   // Grant is combinational so the rvalid cycle can already accept the next request.
   assign gnt = (state_q == ST_IDLE) && req_i && !rst_i;

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rvalid_d = 1'b0;
      rdata_d  = rdata_q;
      err_d    = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (gnt) begin
               state_d = ST_SETUP;
               we_d    = we_i;
               addr_d  = addr_i;
               wdata_d = wdata_i;
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            // A completing pready beats a watchdog expiry in the same cycle.
            if (pready_i) begin
               state_d  = ST_IDLE;
               rvalid_d = 1'b1;
               rdata_d  = we_q ? '0 : prdata_i;
               err_d    = pslverr_i;
            end else if (wd_expire) begin
               state_d  = ST_IDLE;
               rvalid_d = 1'b1;
               rdata_d  = '0;
               err_d    = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

`ifdef APB_MEM_BRIDGE_TIMEOUT_EN
   logic timeout_q, timeout_d;

   apb_bridge_wdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_wdog (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clear_i  (state_q == ST_SETUP),
      .count_i  ((state_q == ST_ACCESS) && !pready_i),
      .expire_o (wd_expire)
   );

   always_comb begin
      timeout_d = timeout_q | wd_expire;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= timeout_d;
      end
   end

   assign timeout_o = timeout_q;
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
   assign wd_expire          = 1'b0;
   assign timeout_o          = 1'b0;
`endif

   // Address/data lines are zeroed outside a transfer so the decode node sees nothing stray.
   assign in_xfer   = (state_q != ST_IDLE);
   assign gnt_o     = gnt;
   assign rvalid_o  = rvalid_q;
   assign rdata_o   = rdata_q;
   assign err_o     = err_q;
   assign psel_o    = in_xfer;
   assign penable_o = (state_q == ST_ACCESS);
   assign pwrite_o  = in_xfer && we_q;
   assign paddr_o   = in_xfer ? (addr_q & WORD_ALIGN_MASK[APB_ADDR_WIDTH-1:0]) : '0;
   assign pwdata_o  = in_xfer ? wdata_q : '0;

endmodule

// File: tb/tb_apb_mem_bridge.sv
// Randomized self-checking bench for apb_mem_bridge with an APB slave model in the bench.
module tb_apb_mem_bridge;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          req, we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          gnt, rvalid, err, psel, penable, pwrite, timeout;
   logic [DW-1:0] rdata, pwdata, prdata;
   logic [AW-1:0] paddr;
   logic          pready, pslverr;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state derived from completed transfers
   logic [DW-1:0] exp_rdata   = '0;
   logic          exp_err     = 1'b0;
   logic          exp_timeout = 1'b0;

   apb_mem_bridge #(
      .APB_ADDR_WIDTH (AW),
      .APB_DATA_WIDTH (DW),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .req_i     (req),
      .we_i      (we),
      .addr_i    (addr),
      .wdata_i   (wdata),
      .gnt_o     (gnt),
      .rvalid_o  (rvalid),
      .rdata_o   (rdata),
      .err_o     (err),
      .psel_o    (psel),
      .penable_o (penable),
      .pwrite_o  (pwrite),
      .paddr_o   (paddr),
      .pwdata_o  (pwdata),
      .prdata_i  (prdata),
      .pready_i  (pready),
      .pslverr_i (pslverr),
      .timeout_o (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   // One complete transfer: request, SETUP, waits+1 ACCESS cycles, response, one hold cycle.
   task automatic do_xfer(input string tag, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input int waits,
                          input logic [DW-1:0] rd, input logic se);
      logic [AW-1:0] exp_paddr;
      exp_paddr = a & 32'hFFFF_FFFC;
      step();
      req = 1'b1; we = w; addr = a; wdata = wd;
      pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
      sample();
      check({tag, ".gnt"}, gnt, 1'b1);
      check({tag, ".idle_paddr"}, paddr, '0);
      step();
      // Core may change its lines once granted
      req = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom;
      pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
      sample();
      check({tag, ".setup_sel"}, {psel, penable}, 2'b10);
      check({tag, ".setup_paddr"}, paddr, exp_paddr);
      check({tag, ".setup_pwdata"}, pwdata, wd);
      check({tag, ".setup_pwrite"}, pwrite, w);
      for (int i = 0; i <= waits; i++) begin
         step();
         pready  = (i == waits);
         prdata  = (i == waits) ? rd : DW'($urandom);
         pslverr = (i == waits) ? se : 1'($urandom);
         sample();
         check({tag, ".acc_sel"}, {psel, penable}, 2'b11);
         check({tag, ".acc_paddr"}, paddr, exp_paddr);
         check({tag, ".acc_pwdata"}, pwdata, wd);
         check({tag, ".acc_pwrite"}, pwrite, w);
         check({tag, ".acc_norv"}, rvalid, 1'b0);
      end
      step();
      pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
      exp_rdata = w ? '0 : rd;
      exp_err   = se;
      sample();
      check({tag, ".rvalid"}, rvalid, 1'b1);
      check({tag, ".rdata"}, rdata, exp_rdata);
      check({tag, ".err"}, err, exp_err);
      check({tag, ".rv_psel"}, psel, 1'b0);
      check({tag, ".rv_paddr"}, paddr, '0);
      check({tag, ".timeout"}, timeout, exp_timeout);
      step();
      pready = 1'b0;
      sample();
      check({tag, ".rv_once"}, rvalid, 1'b0);
      check({tag, ".rdata_hold"}, rdata, exp_rdata);
      check({tag, ".err_hold"}, err, exp_err);
   endtask

   initial begin
      #200000;
      $display("FAIL global_time_limit: got expired expected finish");
      $fatal(1);
   end

   initial begin
      int grants, rvs;
      rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      prdata = '0; pready = 1'b0; pslverr = 1'b0;

      // Reset state
      step(); step();
      sample();
      check("rst.gnt", gnt, 1'b0);
      check("rst.rvalid", rvalid, 1'b0);
      check("rst.psel_pen_pwr", {psel, penable, pwrite}, 3'b000);
      check("rst.paddr", paddr, '0);
      check("rst.pwdata", pwdata, '0);
      check("rst.rdata_err", {rdata, err}, '0);
      check("rst.timeout", timeout, 1'b0);
      step();
      rst = 1'b0;

      // Directed transfers
      do_xfer("rd0", 1'b0, 32'h1A10_0004, 32'h0, 0, 32'h1234_5678, 1'b0);
      do_xfer("wr3", 1'b1, 32'h1A10_1008, 32'hCAFE_F00D, 3, 32'h5555_AAAA, 1'b0);
      do_xfer("rderr", 1'b0, 32'h1A10_0010, 32'h0, 1, 32'hDEAD_BEEF, 1'b1);
      do_xfer("unalign", 1'b0, 32'h1A10_0007, 32'h0, 2, 32'h0BAD_F00D, 1'b0);

      // Back-to-back: request held, slave always ready
      grants = 0; rvs = 0;
      step();
      req = 1'b1; we = 1'b0; addr = 32'h1A10_2000;
      pready = 1'b1; pslverr = 1'b0; prdata = 32'hB0B0_0000;
      for (int c = 0; c < 10; c++) begin
         sample();
         check("b2b.gnt", gnt, (c % 3 == 0) && (c < 9));
         check("b2b.rvalid", rvalid, (c % 3 == 0) && (c > 0));
         if (rvalid) check("b2b.rdata", rdata, 32'hB0B0_0000 + (c / 3) - 1);
         if (c % 3 == 2) check("b2b.paddr", paddr, 32'h1A10_2000 + 4 * (c / 3));
         if (gnt) grants++;
         if (rvalid) rvs++;
         step();
         if (c >= 6) req = 1'b0;
         addr   = 32'h1A10_2000 + 4 * ((c + 1) / 3);
         prdata = 32'hB0B0_0000 + (c + 1) / 3;
      end
      check("b2b.grants", grants, 3);
      check("b2b.rvalids", rvs, 3);
      pready = 1'b0;
      exp_rdata = 32'hB0B0_0002;
      exp_err   = 1'b0;

      // Stuck slave
`ifdef APB_MEM_BRIDGE_TIMEOUT_EN
      step();
      req = 1'b1; we = 1'b0; addr = 32'h1A10_3000; pready = 1'b0;
      sample();
      check("to.gnt", gnt, 1'b1);
      step();
      req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         pready = 1'b0; prdata = $urandom;
         sample();
         check("to.acc_sel", {psel, penable}, 2'b11);
         check("to.acc_norv", rvalid, 1'b0);
      end
      step();
      exp_rdata = '0; exp_err = 1'b1; exp_timeout = 1'b1;
      sample();
      check("to.rvalid", rvalid, 1'b1);
      check("to.err", err, 1'b1);
      check("to.rdata", rdata, '0);
      check("to.timeout", timeout, 1'b1);
      check("to.sel_off", {psel, penable}, 2'b00);
      // pready arriving in the limit cycle completes normally; timeout stays sticky
      do_xfer("to_edge", 1'b0, 32'h1A10_3004, 32'h0, 3, 32'h7777_1111, 1'b0);
`else
      do_xfer("nowdog", 1'b0, 32'h1A10_3000, 32'h0, 12, 32'h7777_1111, 1'b0);
`endif

      // Reset during ACCESS, in the very cycle pready would complete
      step();
      req = 1'b1; we = 1'b1; addr = 32'h1A10_4000; wdata = 32'h0F0F_0F0F;
      sample();
      check("rmid.gnt", gnt, 1'b1);
      step();
      req = 1'b0;
      step();
      pready = 1'b0;
      sample();
      check("rmid.acc", {psel, penable}, 2'b11);
      step();
      rst = 1'b1; pready = 1'b1; prdata = 32'h9999_9999; pslverr = 1'b1;
      step();
      req = 1'b1;
      sample();
      check("rmid.sel", {psel, penable, pwrite}, 3'b000);
      check("rmid.rvalid", rvalid, 1'b0);
      check("rmid.gnt", gnt, 1'b0);
      check("rmid.paddr_pwdata", {paddr, pwdata}, '0);
      check("rmid.rdata_err", {rdata, err}, '0);
      check("rmid.timeout", timeout, 1'b0);
      step();
      rst = 1'b0; req = 1'b0; pready = 1'b0; pslverr = 1'b0;
      sample();
      check("rmid.after_rv", rvalid, 1'b0);
      check("rmid.after_sel", psel, 1'b0);
      exp_rdata = '0; exp_err = 1'b0; exp_timeout = 1'b0;

      // Randomized transfers
      for (int n = 0; n < 24; n++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            step();
            pready = 1'($urandom); pslverr = 1'($urandom);
            sample();
            check("rnd.idle_rv", rvalid, 1'b0);
         end
         pready = 1'b0;
         do_xfer("rnd", 1'($urandom), $urandom, $urandom, $urandom_range(0, 3),
                 $urandom, ($urandom_range(0, 3) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
